// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status type and pointer-width helper for the synchronous FIFO.
package fifo_pkg;
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array with one write port and an asynchronous read port.
// Contents clear to zero on the asynchronous active-low reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock show-ahead FIFO with occupancy count and thresholds.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags (tied to 0 otherwise).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  write_en,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  read_en,
    output logic [WIDTH-1:0]      read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] AF = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE = PW'(AE_THRESH);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
    logic          w_rd_acc, w_wr_acc;
    fifo_status_t  w_status;

    always_comb begin
        w_status.empty        = r_wr_ptr == r_rd_ptr;
        w_status.full         = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                                (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
        w_status.almost_full  = r_count >= AF;
        w_status.almost_empty = r_count <= AE;
    end

    // A read at full frees the slot the write lands in, so both are taken.
    assign w_rd_acc = read_en && !w_status.empty;
    assign w_wr_acc = write_en && (!w_status.full || w_rd_acc);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_wr_acc && !w_rd_acc) r_count <= r_count + PW'(1);
            else if (w_rd_acc && !w_wr_acc) r_count <= r_count - PW'(1);
        end
    end

    fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rstN  (rstN),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr[PW-2:0]),
        .wdata (write_data),
        .raddr (r_rd_ptr[PW-2:0]),
        .rdata (read_data)
    );

    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign count        = r_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (write_en && !w_wr_acc) || (r_overflow && !err_clr);
            r_underflow <= (read_en && w_status.empty) || (r_underflow && !err_clr);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused;

    assign w_unused  = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table-driven vectors plus a queue scoreboard for sync_fifo_param (8x8).
module tb_sync_fifo_param;
    localparam int DEPTH = 8;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk, rstN, write_en, read_en, err_clr;
    logic [7:0] write_data, read_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .write_en     (write_en),
        .write_data   (write_data),
        .read_en      (read_en),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] q [$];
    logic       m_ovf, m_udf;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check show-ahead data before the edge, state after it.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        logic m_rd, m_wr;
        int   sz;
        @(negedge clk);
        write_en = we; write_data = wd; read_en = re; err_clr = clr;
        #1;
        sz   = q.size();
        m_rd = re && sz != 0;
        m_wr = we && (sz < DEPTH || m_rd);
        if (m_rd) chk("rd_data", read_data, q.pop_front());
        if (m_wr) q.push_back(wd);
        m_ovf = ERR_EN && ((we && !m_wr) || (m_ovf && !clr));
        m_udf = ERR_EN && ((re && sz == 0) || (m_udf && !clr));
        @(posedge clk);
        #1;
        chk("count", count, q.size());
        chk("status {full,empty,af,ae,ovf,udf}",
            {full, empty, almost_full, almost_empty, overflow, underflow},
            {q.size() == DEPTH, q.size() == 0, q.size() >= 6, q.size() <= 1, m_ovf, m_udf});
    endtask

    initial begin
        for (int i = 0; i < 18; i++) begin
            int c;
            c = (i < 8) ? i + 1 : (i == 8) ? 8 : (16 - i > 0 ? 16 - i : 0);
            tbl[i] = '{i < 9, 8'(8'h11 * (i + 1)), i >= 9, c, c == 8, c == 0, c >= 6, c <= 1};
        end

        rstN = 1'b0; write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0; write_data = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        #12;
        chk("rst count", count, 0);
        chk("rst status", {full, empty, almost_full, almost_empty, overflow, underflow}, 6'b010100);
        chk("rst read_data", read_data, 0);
        @(negedge clk) rstN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re, 1'b0);
            chk($sformatf("tbl[%0d] count", i), count, tbl[i].cnt);
            chk($sformatf("tbl[%0d] flags", i), {full, empty, almost_full, almost_empty},
                {tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae});
        end
        chk("overflow sticky", overflow, ERR_EN);
        chk("underflow sticky", underflow, ERR_EN);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("err_clr", {overflow, underflow}, 2'b00);

        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("full rw count", count, 8);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("a5 at head", read_data, 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("empty rw data", read_data, 8'h3C);
        chk("empty rw flags", {count, empty, almost_empty}, {4'd1, 1'b0, 1'b1});
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), i >= 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b0);

        while (q.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
        while (q.size() < 5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("pre-reset count", count, 5);
        @(negedge clk);
        write_en = 1'b1; write_data = 8'hEE; read_en = 1'b0;
        #2 rstN = 1'b0;
        #1;
        chk("async rst count", count, 0);
        chk("async rst empty", empty, 1'b1);
        chk("async rst read_data", read_data, 0);
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        write_en = 1'b0;
        @(negedge clk) rstN = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
